snake_step_ctrl: RTL and testbench

Sequencer for one snake game step. It paces moves with a speed-weighted tick accumulator and drives the shared game datapath through a single req/ack phase handshake: head update, collision/eat check, item respawn, body shift. It also owns speed boost, score, pause, start seed and game-over. It sits between the joystick/pause inputs and the head/body/item datapath, and feeds score to the FND decoder.

---
 rtl/snake_pkg.sv | 45 ++++
 rtl/snake_tick_gen.sv | 48 ++++
 rtl/snake_step_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_snake_step_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake step sequencer:
//   - state_e : controller FSM states, also driven out on o_State
//   - phase_e : datapath phase code carried on o_Phase
//   - default/limit constants for speed and score
//   - state_to_phase : maps a phase state to its phase code
// -----------------------------------------------------------------------------
package snake_pkg;

  localparam int unsigned SPD_W     = 5;
  localparam int unsigned SCORE_W   = 10;
  localparam int unsigned DEF_SPD   = 2;
  localparam int unsigned MAX_SPD   = 31;
  localparam int unsigned SCORE_MAX = 999;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HEAD  = 3'd2,
    ST_CHECK = 3'd3,
    ST_ITEM  = 3'd4,
    ST_BODY  = 3'd5,
    ST_PAUSE = 3'd6,
    ST_STOP  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    PH_HEAD  = 2'd0,
    PH_CHECK = 2'd1,
    PH_ITEM  = 2'd2,
    PH_BODY  = 2'd3
  } phase_e;

  // Non-phase states report HEAD (code 0), the idle value of o_Phase.
  function automatic phase_e state_to_phase(input state_e s);
    case (s)
      ST_CHECK: return PH_CHECK;
      ST_ITEM:  return PH_ITEM;
      ST_BODY:  return PH_BODY;
      default:  return PH_HEAD;
    endcase
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// -----------------------------------------------------------------------------
// snake_tick_gen
// Speed-weighted move pacer. While enabled, the accumulator adds the current
// speed each cycle; when acc+speed reaches TICK_MAX a one-cycle tick is issued
// and the accumulator restarts from zero. When disabled the accumulator holds.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : force accumulator to zero (game start)
//   en_i         : accumulate this cycle (controller in WAIT, not paused)
//   speed_i      : increment per enabled cycle
//   tick_o       : one-cycle move pulse
// -----------------------------------------------------------------------------
module snake_tick_gen import snake_pkg::*; #(
  parameter int unsigned TICK_MAX = 25_000_000,
  parameter int unsigned CNT_W    = 25
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [SPD_W-1:0] speed_i,
  output logic             tick_o
);

  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] sum;

  always_comb begin
    sum    = {1'b0, acc_q} + SUM_W'(speed_i);
    tick_o = en_i && (sum >= SUM_W'(TICK_MAX));
    acc_d  = acc_q;
    if (clr_i || tick_o) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum[CNT_W-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/snake_step_ctrl.sv
// -----------------------------------------------------------------------------
// snake_step_ctrl
// Sequencer for one snake game step. A tick from snake_tick_gen starts a step;
// the datapath is then walked through HEAD -> CHECK -> (ITEM) -> BODY with a
// req/ack handshake (transfer = o_Req && i_Ack). Also owns speed boost, score,
// pause, start seed and game-over.
// Ports:
//   i_Clk, i_Rst : clock, asynchronous active-high reset
//   i_Start      : any joystick press; leaves IDLE and captures the seed
//   i_Pause      : pause request, honoured only in WAIT/PAUSE
//   i_Ack        : datapath finished the current phase
//   i_Eat/i_Dead : CHECK result, sampled only on the CHECK transfer
//   o_Req        : phase request, decoded from state
//   o_Phase      : 0 HEAD, 1 CHECK, 2 ITEM, 3 BODY
//   o_Speed      : current speed, o_Score : saturating score (max 999)
//   o_Seed       : free-run count captured at start
//   o_State      : FSM state, o_GameOver : high in STOP
//   o_Err        : sticky phase timeout
// Build option: define SNAKE_PHASE_TIMEOUT_EN to add a per-phase watchdog
// (parameter TIMEOUT); otherwise phases wait forever and o_Err is tied 0.
// -----------------------------------------------------------------------------
module snake_step_ctrl #(
  parameter int unsigned TICK_MAX    = 25_000_000,
  parameter int unsigned CNT_W       = 25,
  parameter int unsigned DEF_SPD     = snake_pkg::DEF_SPD,
  parameter int unsigned MAX_SPD     = snake_pkg::MAX_SPD,
  parameter int unsigned BOOST_STEPS = 16
`ifdef SNAKE_PHASE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT   = 255
`endif
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic             i_Pause,
  input  logic             i_Ack,
  input  logic             i_Eat,
  input  logic             i_Dead,
  output logic             o_Req,
  output logic [1:0]       o_Phase,
  output logic [4:0]       o_Speed,
  output logic [9:0]       o_Score,
  output logic [CNT_W-1:0] o_Seed,
  output logic [2:0]       o_State,
  output logic             o_GameOver,
  output logic             o_Err
);

  import snake_pkg::*;

  localparam int unsigned BW = $clog2(BOOST_STEPS + 1);
  localparam logic [SPD_W-1:0]   SPD_DEF_L  = SPD_W'(DEF_SPD);
  localparam logic [SPD_W-1:0]   SPD_MAX_L  = SPD_W'(MAX_SPD);
  localparam logic [SCORE_W-1:0] SCORE_MAX_L = SCORE_W'(SCORE_MAX);

  state_e             state_q, state_d;
  logic [SPD_W-1:0]   speed_q, speed_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [BW-1:0]      boost_q, boost_d, boost_inc;
  logic [CNT_W-1:0]   free_q, free_d, seed_q, seed_d;
  logic [SCORE_W:0]   score_sum;
  logic               req, tick, timeout;

  assign req = (state_q == ST_HEAD) || (state_q == ST_CHECK) ||
               (state_q == ST_ITEM) || (state_q == ST_BODY);

  snake_tick_gen #(
    .TICK_MAX (TICK_MAX),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk_i   (i_Clk),
    .rst_i   (i_Rst),
    .clr_i   ((state_q == ST_IDLE) && i_Start),
    .en_i    ((state_q == ST_WAIT) && !i_Pause),
    .speed_i (speed_q),
    .tick_o  (tick)
  );

`ifdef SNAKE_PHASE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q;

  // Counts stalled cycles of the current phase; any ack (phase change) or
  // non-phase state restarts it, so each phase entry begins at zero.
  always_comb begin
    timer_d = '0;
    timeout = 1'b0;
    if (req && !i_Ack) begin
      timer_d = timer_q + 1'b1;
      timeout = (timer_d == TW'(TIMEOUT));
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_q | timeout;
    end
  end

  assign o_Err = err_q;
`else
  assign timeout = 1'b0;
  assign o_Err   = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output is given a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    speed_d   = speed_q;
    score_d   = score_q;
    boost_d   = boost_q;
    seed_d    = seed_q;
    free_d    = free_q;
    boost_inc = boost_q + 1'b1;
    score_sum = {1'b0, score_q} + (SCORE_W + 1)'(speed_q >> 1);

    case (state_q)
      ST_IDLE: begin
        free_d = free_q + 1'b1;
        if (i_Start) begin
          seed_d  = free_q;
          state_d = ST_WAIT;
        end
      end
      // Pause wins over a same-cycle tick; the tick gen is disabled too.
      ST_WAIT:  if (i_Pause) state_d = ST_PAUSE;
                else if (tick) state_d = ST_HEAD;
      ST_PAUSE: if (!i_Pause) state_d = ST_WAIT;
      ST_HEAD:  if (i_Ack) state_d = ST_CHECK;
      ST_CHECK: begin
        if (i_Ack) begin
          if (i_Dead) begin
            state_d = ST_STOP;
          end else if (i_Eat) begin
            state_d = ST_ITEM;
            // Score uses the speed before this eat's increment.
            score_d = (score_sum > {1'b0, SCORE_MAX_L}) ? SCORE_MAX_L
                                                         : score_sum[SCORE_W-1:0];
            speed_d = (speed_q >= SPD_MAX_L) ? speed_q : speed_q + 1'b1;
            boost_d = '0;
          end else begin
            state_d = ST_BODY;
          end
        end
      end
      ST_ITEM:  if (i_Ack) state_d = ST_BODY;
      ST_BODY: begin
        if (i_Ack) begin
          state_d = ST_WAIT;
          // Boost window counts every completed step, even at default speed.
          if (boost_inc == BW'(BOOST_STEPS)) begin
            speed_d = SPD_DEF_L;
            boost_d = '0;
          end else begin
            boost_d = boost_inc;
          end
        end
      end
      default: state_d = ST_STOP;
    endcase

    if (timeout) state_d = ST_STOP;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      speed_q <= SPD_DEF_L;
      score_q <= '0;
      boost_q <= '0;
      seed_q  <= '0;
      free_q  <= '0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      score_q <= score_d;
      boost_q <= boost_d;
      seed_q  <= seed_d;
      free_q  <= free_d;
    end
  end

  assign o_Req      = req;
  assign o_Phase    = state_to_phase(state_q);
  assign o_Speed    = speed_q;
  assign o_Score    = score_q;
  assign o_Seed     = seed_q;
  assign o_State    = state_q;
  assign o_GameOver = (state_q == ST_STOP);

endmodule

// File: tb/tb_snake_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_step_ctrl
// Directed bench for snake_step_ctrl with TICK_MAX=10, DEF_SPD=2. Expected
// phase codes are queued when a step is launched and popped as the DUT walks
// the handshake; speed/score come from a small reference model of the rules.
// -----------------------------------------------------------------------------
module tb_snake_step_ctrl;
  import snake_pkg::*;

  localparam int TICK_MAX    = 10;
  localparam int CNT_W       = 25;
  localparam int DEF_SPD_T   = 2;
  localparam int MAX_SPD_T   = 31;
  localparam int BOOST_STEPS = 16;
  localparam int SCORE_LIM   = 999;
`ifdef SNAKE_PHASE_TIMEOUT_EN
  localparam int TIMEOUT     = 8;
`endif

  logic             i_Clk = 1'b0;
  logic             i_Rst = 1'b1;
  logic             i_Start = 1'b0, i_Pause = 1'b0, i_Ack = 1'b0;
  logic             i_Eat = 1'b0, i_Dead = 1'b0;
  logic             o_Req, o_GameOver, o_Err;
  logic [1:0]       o_Phase;
  logic [4:0]       o_Speed;
  logic [9:0]       o_Score;
  logic [CNT_W-1:0] o_Seed;
  logic [2:0]       o_State;

  int vectors = 0;
  int fails   = 0;
  int m_spd   = DEF_SPD_T;
  int m_score = 0;
  int m_boost = 0;
  logic [1:0] exp_q[$];

  snake_step_ctrl #(
    .TICK_MAX    (TICK_MAX),
    .CNT_W       (CNT_W),
    .DEF_SPD     (DEF_SPD_T),
    .MAX_SPD     (MAX_SPD_T),
    .BOOST_STEPS (BOOST_STEPS)
`ifdef SNAKE_PHASE_TIMEOUT_EN
    , .TIMEOUT   (TIMEOUT)
`endif
  ) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Start    (i_Start),
    .i_Pause    (i_Pause),
    .i_Ack      (i_Ack),
    .i_Eat      (i_Eat),
    .i_Dead     (i_Dead),
    .o_Req      (o_Req),
    .o_Phase    (o_Phase),
    .o_Speed    (o_Speed),
    .o_Score    (o_Score),
    .o_Seed     (o_Seed),
    .o_State    (o_State),
    .o_GameOver (o_GameOver),
    .o_Err      (o_Err)
  );

  always #5 i_Clk = ~i_Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int spd);
    return (TICK_MAX + spd - 1) / spd;
  endfunction

  // Counts negedges until o_Req is seen, bounded.
  task automatic wait_req(output int n);
    n = 0;
    while (!o_Req && n < 200) begin
      @(negedge i_Clk);
      n++;
    end
  endtask

  task automatic reset_model();
    m_spd   = DEF_SPD_T;
    m_score = 0;
    m_boost = 0;
  endtask

  // Called on a negedge with reset asserted; releases it, idles k cycles,
  // starts the game and returns on the first WAIT negedge.
  task automatic start_game(input int k);
    i_Rst = 1'b0;
    repeat (k) @(posedge i_Clk);
    @(negedge i_Clk);
    i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    check("start_state", o_State, ST_WAIT);
    check("seed", o_Seed, k);
  endtask

  // One full step with ack held high; starts and ends on a WAIT negedge.
  task automatic do_step(input bit eat, input bit dead, input bit pause_body,
                         input int lat_exp);
    int n;
    logic [1:0] e;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    if (!dead) begin
      if (eat) exp_q.push_back(2'd2);
      exp_q.push_back(2'd3);
    end
    i_Ack  = 1'b1;
    i_Eat  = eat;
    i_Dead = dead;
    wait_req(n);
    check("req_latency", n, lat_exp);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("phase", {o_Req, o_Phase}, {1'b1, e});
      if (pause_body && e == 2'd3) i_Pause = 1'b1;
      @(negedge i_Clk);
    end
    i_Ack  = 1'b0;
    i_Eat  = 1'b0;
    i_Dead = 1'b0;
    if (!dead) begin
      if (eat) begin
        m_score = (m_score + m_spd / 2 > SCORE_LIM) ? SCORE_LIM : m_score + m_spd / 2;
        m_spd   = (m_spd < MAX_SPD_T) ? m_spd + 1 : m_spd;
        m_boost = 0;
      end
      m_boost++;
      if (m_boost == BOOST_STEPS) begin
        m_spd   = DEF_SPD_T;
        m_boost = 0;
      end
    end
    check("state_after_step", o_State, dead ? ST_STOP : ST_WAIT);
    check("speed", o_Speed, m_spd);
    check("score", o_Score, m_score);
  endtask

  initial begin
    int n;
    @(negedge i_Clk);
    check("rst_state", o_State, ST_IDLE);
    check("rst_req", o_Req, 0);
    check("rst_phase", o_Phase, 0);
    check("rst_speed", o_Speed, DEF_SPD_T);
    check("rst_score", o_Score, 0);
    check("rst_seed", o_Seed, 0);
    check("rst_gameover", o_GameOver, 0);
    check("rst_err", o_Err, 0);

    start_game(7);

    // Plain step, then an eat at speed 2.
    do_step(0, 0, 0, lat(m_spd));
    check("plain_score", o_Score, 0);
    do_step(1, 0, 0, lat(m_spd));
    check("eat_score", o_Score, 1);
    check("eat_speed", o_Speed, 3);

    // Boost window: still boosted after 14 further steps, default after 16.
    for (int i = 0; i < 16; i++) begin
      do_step(0, 0, 0, lat(m_spd));
      if (i == 13) check("boost_held", o_Speed, 3);
    end
    check("boost_expired", o_Speed, DEF_SPD_T);

    // Pause raised during BODY takes effect after the step, in WAIT.
    do_step(0, 0, 1, lat(m_spd));
    @(negedge i_Clk);
    check("pause_entered", o_State, ST_PAUSE);
    repeat (4) @(negedge i_Clk);
    check("pause_hold", o_State, ST_PAUSE);
    check("pause_no_req", o_Req, 0);
    // Two WAIT cycles of accumulation, pause again, then only the rest remains.
    i_Pause = 1'b0;
    repeat (3) @(negedge i_Clk);
    check("wait_before_repause", o_State, ST_WAIT);
    i_Pause = 1'b1;
    repeat (5) @(negedge i_Clk);
    check("repause_hold", o_State, ST_PAUSE);
    i_Pause = 1'b0;
    do_step(0, 0, 0, lat(m_spd) - 1);

    // Repeated eats drive speed and score into saturation.
    for (int i = 0; i < 90; i++) do_step(1, 0, 0, lat(m_spd));
    check("speed_sat", o_Speed, MAX_SPD_T);
    check("score_sat", o_Score, SCORE_LIM);

    // Reset in the middle of a phase drops o_Req without a clock edge.
    wait_req(n);
    check("stall_req_latency", n, lat(m_spd));
    #2 i_Rst = 1'b1;
    #1;
    check("async_req_drop", o_Req, 0);
    check("async_state", o_State, ST_IDLE);
    check("async_score", o_Score, 0);
    reset_model();
    @(negedge i_Clk);
    start_game(3);

    // Stalled phase: watchdog when built in, indefinite wait otherwise.
    wait_req(n);
    check("head_latency", n, lat(m_spd));
`ifdef SNAKE_PHASE_TIMEOUT_EN
    n = 0;
    while (o_Req && n < 50) begin
      @(negedge i_Clk);
      n++;
    end
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_state", o_State, ST_STOP);
    check("timeout_err", o_Err, 1);
    check("timeout_gameover", o_GameOver, 1);
`else
    repeat (40) @(negedge i_Clk);
    check("stall_state", o_State, ST_HEAD);
    check("stall_req", o_Req, 1);
    check("stall_err", o_Err, 0);
`endif
    i_Rst = 1'b1;
    @(negedge i_Clk);
    check("rst_err_clear", o_Err, 0);
    reset_model();
    start_game(4);

    // Dead wins over eat; STOP ignores everything afterwards.
    do_step(1, 0, 0, lat(m_spd));
    do_step(1, 1, 0, lat(m_spd));
    check("dead_gameover", o_GameOver, 1);
    check("dead_score", o_Score, 1);
    check("dead_speed", o_Speed, 3);
    i_Ack   = 1'b1;
    i_Start = 1'b1;
    i_Pause = 1'b1;
    repeat (20) @(negedge i_Clk);
    check("stop_state", o_State, ST_STOP);
    check("stop_req", o_Req, 0);
    check("stop_score", o_Score, 1);
    check("stop_gameover", o_GameOver, 1);
    i_Ack   = 1'b0;
    i_Start = 1'b0;
    i_Pause = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
